// File: rtl/e203_fpu_wbck_pkg.sv
// Shared types and constants for the FPU write-back stage.
// Entry layout depends on E203_FPU_FFLAGS_EN (flags field present only when defined).
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif

package e203_fpu_wbck_pkg;

    localparam int FLEN    = 32;
    localparam int RFIDX_W = `E203_RFIDX_WIDTH;
    localparam int FFLAG_W = 5;

    // fflags bit positions
    localparam int FFLAG_NV = 4;
    localparam int FFLAG_DZ = 3;
    localparam int FFLAG_OF = 2;
    localparam int FFLAG_UF = 1;
    localparam int FFLAG_NX = 0;

    typedef struct packed {
        logic [FLEN-1:0]    wdat;
        logic [RFIDX_W-1:0] rdidx;
        logic               rdwen;
        logic               rdfpu;
`ifdef E203_FPU_FFLAGS_EN
        logic [FFLAG_W-1:0] fflags;
`endif
    } wbck_entry_t;

    localparam int ENTRY_W = $bits(wbck_entry_t);

endpackage

// File: rtl/e203_fpu_wbck_fifo.sv
// Generic valid/ready FIFO; pointers carry one extra wrap bit so full and
// empty are distinguishable. No same-cycle pass-through.
module e203_fpu_wbck_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_dat,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] pop_dat,
    output logic              full,
    output logic              empty
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W  = ADDR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign push_ready = !full;
    assign pop_valid  = !empty;
    assign pop_dat    = mem[rd_ptr[ADDR_W-1:0]];

    assign do_push = push_valid && push_ready;
    assign do_pop  = pop_valid && pop_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage is data only; validity is carried entirely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= push_dat;
    end

endmodule

// File: rtl/e203_fpu_wbck.sv
// FPU result write-back: buffers results, routes them to the FP regfile or the
// integer long-pipe write-back, and accumulates fflags when E203_FPU_FFLAGS_EN is defined.
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif

module e203_fpu_wbck
    import e203_fpu_wbck_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fpu_o_valid,
    output logic                         fpu_o_ready,
    input  logic [31:0]                  fpu_o_wdat,
    input  logic [`E203_RFIDX_WIDTH-1:0] fpu_o_rdidx,
    input  logic                         fpu_o_rdwen,
    input  logic                         fpu_o_rdfpu,
    input  logic [4:0]                   fpu_o_fflags,
    output logic                         frf_wen,
    output logic [`E203_RFIDX_WIDTH-1:0] frf_widx,
    output logic [31:0]                  frf_wdat,
    output logic                         int_wbck_valid,
    input  logic                         int_wbck_ready,
    output logic [`E203_RFIDX_WIDTH-1:0] int_wbck_rdidx,
    output logic [31:0]                  int_wbck_wdat,
    input  logic                         csr_fflags_wen,
    input  logic [4:0]                   csr_fflags_wdat,
    output logic [4:0]                   csr_fflags_r,
    output logic                         fpu_wbck_busy
);

    wbck_entry_t        push_entry;
    wbck_entry_t        head;
    logic [ENTRY_W-1:0] head_raw;
    logic               head_valid;
    logic               fifo_full;
    logic               fifo_empty;
    logic               retire;
    logic               head_is_fp;
    logic               head_is_int;

    always_comb begin
        push_entry       = '0;
        push_entry.wdat  = fpu_o_wdat;
        push_entry.rdidx = fpu_o_rdidx;
        push_entry.rdwen = fpu_o_rdwen;
        push_entry.rdfpu = fpu_o_rdfpu;
`ifdef E203_FPU_FFLAGS_EN
        push_entry.fflags = fpu_o_fflags;
`endif
    end

    e203_fpu_wbck_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (fpu_o_valid),
        .push_ready (fpu_o_ready),
        .push_dat   (push_entry),
        .pop_valid  (head_valid),
        .pop_ready  (retire),
        .pop_dat    (head_raw),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign head          = head_raw;
    assign fpu_wbck_busy = !fifo_empty;

    // Head routing: FP writes never stall, integer writes wait for the core.
    assign head_is_fp  = head_valid && head.rdwen &&  head.rdfpu;
    assign head_is_int = head_valid && head.rdwen && !head.rdfpu;
    assign retire      = head_valid && (!head.rdwen || head.rdfpu || int_wbck_ready);

    // Data outputs are gated so nothing stale from the buffer leaks while idle.
    assign frf_wen        = head_is_fp;
    assign frf_widx       = head_is_fp  ? head.rdidx : '0;
    assign frf_wdat       = head_is_fp  ? head.wdat  : '0;
    assign int_wbck_valid = head_is_int;
    assign int_wbck_rdidx = head_is_int ? head.rdidx : '0;
    assign int_wbck_wdat  = head_is_int ? head.wdat  : '0;

`ifdef E203_FPU_FFLAGS_EN
    logic [FFLAG_W-1:0] fflags_q;
    logic [FFLAG_W-1:0] retire_flags;
    logic               unused_full;

    assign retire_flags = retire ? head.fflags : '0;
    assign unused_full  = fifo_full;

    // A CSR write replaces the accumulated value but still absorbs a same-cycle retire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fflags_q <= '0;
        end else if (csr_fflags_wen) begin
            fflags_q <= csr_fflags_wdat | retire_flags;
        end else begin
            fflags_q <= fflags_q | retire_flags;
        end
    end

    assign csr_fflags_r = fflags_q;
`else
    logic unused_flags;

    assign unused_flags = ^{csr_fflags_wen, csr_fflags_wdat, fpu_o_fflags, fifo_full};
    assign csr_fflags_r = '0;
`endif

endmodule

// File: tb/tb_e203_fpu_wbck.sv
// Directed bench for e203_fpu_wbck; fflags expectations follow E203_FPU_FFLAGS_EN.
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif

module tb_e203_fpu_wbck;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic                         fpu_o_valid;
    logic                         fpu_o_ready;
    logic [31:0]                  fpu_o_wdat;
    logic [`E203_RFIDX_WIDTH-1:0] fpu_o_rdidx;
    logic                         fpu_o_rdwen;
    logic                         fpu_o_rdfpu;
    logic [4:0]                   fpu_o_fflags;
    logic                         frf_wen;
    logic [`E203_RFIDX_WIDTH-1:0] frf_widx;
    logic [31:0]                  frf_wdat;
    logic                         int_wbck_valid;
    logic                         int_wbck_ready;
    logic [`E203_RFIDX_WIDTH-1:0] int_wbck_rdidx;
    logic [31:0]                  int_wbck_wdat;
    logic                         csr_fflags_wen;
    logic [4:0]                   csr_fflags_wdat;
    logic [4:0]                   csr_fflags_r;
    logic                         fpu_wbck_busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    e203_fpu_wbck #(.FIFO_DEPTH(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fpu_o_valid     (fpu_o_valid),
        .fpu_o_ready     (fpu_o_ready),
        .fpu_o_wdat      (fpu_o_wdat),
        .fpu_o_rdidx     (fpu_o_rdidx),
        .fpu_o_rdwen     (fpu_o_rdwen),
        .fpu_o_rdfpu     (fpu_o_rdfpu),
        .fpu_o_fflags    (fpu_o_fflags),
        .frf_wen         (frf_wen),
        .frf_widx        (frf_widx),
        .frf_wdat        (frf_wdat),
        .int_wbck_valid  (int_wbck_valid),
        .int_wbck_ready  (int_wbck_ready),
        .int_wbck_rdidx  (int_wbck_rdidx),
        .int_wbck_wdat   (int_wbck_wdat),
        .csr_fflags_wen  (csr_fflags_wen),
        .csr_fflags_wdat (csr_fflags_wdat),
        .csr_fflags_r    (csr_fflags_r),
        .fpu_wbck_busy   (fpu_wbck_busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ff(input logic [4:0] v);
`ifdef E203_FPU_FFLAGS_EN
        return {27'd0, v};
`else
        return 32'd0;
`endif
    endfunction

    // Advance one clock; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] d,
                         input logic wen, input logic fpu, input logic [4:0] fl);
        fpu_o_valid  = v;
        fpu_o_rdidx  = rd;
        fpu_o_wdat   = d;
        fpu_o_rdwen  = wen;
        fpu_o_rdfpu  = fpu;
        fpu_o_fflags = fl;
    endtask

    task automatic idle_in();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    endtask

    initial begin
        rst_n           = 1'b0;
        int_wbck_ready  = 1'b0;
        csr_fflags_wen  = 1'b0;
        csr_fflags_wdat = 5'd0;
        idle_in();
        @(negedge clk);
        step();
        chk("rst_ready",  {31'd0, fpu_o_ready},    32'd1);
        chk("rst_busy",   {31'd0, fpu_wbck_busy},  32'd0);
        chk("rst_frfwen", {31'd0, frf_wen},        32'd0);
        chk("rst_intv",   {31'd0, int_wbck_valid}, 32'd0);
        chk("rst_fflags", {27'd0, csr_fflags_r},   32'd0);
        chk("rst_frfdat", frf_wdat,                32'd0);
        rst_n = 1'b1;
        step();

        // FP result rd=3 lands on the FP port exactly one cycle after acceptance
        drive(1'b1, 5'd3, 32'h3F80_0000, 1'b1, 1'b1, 5'd0);
        step();
        idle_in();
        chk("fp_wen",  {31'd0, frf_wen},        32'd1);
        chk("fp_widx", {27'd0, frf_widx},       32'd3);
        chk("fp_wdat", frf_wdat,                32'h3F80_0000);
        chk("fp_intv", {31'd0, int_wbck_valid}, 32'd0);
        step();
        chk("fp_once", {31'd0, frf_wen},        32'd0);
        chk("fp_idle", {31'd0, fpu_wbck_busy},  32'd0);

        // Integer result held while ready is low, then followed by an FP result
        drive(1'b1, 5'd10, 32'h1, 1'b1, 1'b0, 5'd0);
        step();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            chk("int_hold_v",   {31'd0, int_wbck_valid}, 32'd1);
            chk("int_hold_idx", {27'd0, int_wbck_rdidx}, 32'd10);
            chk("int_hold_dat", int_wbck_wdat,           32'h1);
            chk("int_hold_frf", {31'd0, frf_wen},        32'd0);
            if (i < 2) step();
        end
        int_wbck_ready = 1'b1;
        drive(1'b1, 5'd5, 32'h4000_0000, 1'b1, 1'b1, 5'd0);
        step();
        idle_in();
        int_wbck_ready = 1'b0;
        chk("int_retired", {31'd0, int_wbck_valid}, 32'd0);
        chk("fp2_wen",     {31'd0, frf_wen},        32'd1);
        chk("fp2_widx",    {27'd0, frf_widx},       32'd5);
        chk("fp2_wdat",    frf_wdat,                32'h4000_0000);
        step();
        chk("fp2_once",    {31'd0, frf_wen},        32'd0);

        // FSW-style entry: no regfile write, flags accumulate
        drive(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'h01);
        step();
        idle_in();
        chk("fsw_frf",  {31'd0, frf_wen},        32'd0);
        chk("fsw_intv", {31'd0, int_wbck_valid}, 32'd0);
        chk("fsw_busy", {31'd0, fpu_wbck_busy},  32'd1);
        step();
        chk("fsw_flags", {27'd0, csr_fflags_r},  ff(5'h01));
        chk("fsw_drain", {31'd0, fpu_wbck_busy}, 32'd0);

        // Fill with integer results while ready is low, then drain across pointer wrap
        drive(1'b1, 5'd1, 32'h11, 1'b1, 1'b0, 5'd0);
        step();
        drive(1'b1, 5'd2, 32'h22, 1'b1, 1'b0, 5'd0);
        step();
        chk("full_ready", {31'd0, fpu_o_ready},   32'd0);
        chk("full_busy",  {31'd0, fpu_wbck_busy}, 32'd1);
        drive(1'b1, 5'd3, 32'h33, 1'b1, 1'b0, 5'd0);
        step();
        chk("full_stall", {31'd0, fpu_o_ready},   32'd0);
        chk("drain_a_idx", {27'd0, int_wbck_rdidx}, 32'd1);
        chk("drain_a_dat", int_wbck_wdat,           32'h11);
        int_wbck_ready = 1'b1;
        step();
        chk("no_passthru", {31'd0, fpu_o_ready},    32'd1);
        chk("drain_b_idx", {27'd0, int_wbck_rdidx}, 32'd2);
        chk("drain_b_dat", int_wbck_wdat,           32'h22);
        step();
        idle_in();
        chk("drain_c_idx", {27'd0, int_wbck_rdidx}, 32'd3);
        chk("drain_c_dat", int_wbck_wdat,           32'h33);
        step();
        int_wbck_ready = 1'b0;
        chk("drain_done", {31'd0, int_wbck_valid}, 32'd0);
        chk("drain_busy", {31'd0, fpu_wbck_busy},  32'd0);

        // CSR write coinciding with a retire keeps the retiring flags
        drive(1'b1, 5'd7, 32'h1234_5678, 1'b1, 1'b1, 5'h10);
        step();
        idle_in();
        csr_fflags_wen  = 1'b1;
        csr_fflags_wdat = 5'h00;
        step();
        chk("csr_retire", {27'd0, csr_fflags_r}, ff(5'h10));
        csr_fflags_wdat = 5'h04;
        step();
        csr_fflags_wen  = 1'b0;
        chk("csr_write",  {27'd0, csr_fflags_r}, ff(5'h04));
        step();
        chk("csr_hold",   {27'd0, csr_fflags_r}, ff(5'h04));

        // Reset with two buffered entries
        drive(1'b1, 5'd8, 32'h88, 1'b1, 1'b0, 5'h02);
        step();
        drive(1'b1, 5'd9, 32'h99, 1'b1, 1'b0, 5'h08);
        step();
        idle_in();
        chk("pre_rst_busy", {31'd0, fpu_wbck_busy}, 32'd1);
        rst_n = 1'b0;
        step();
        chk("mrst_busy",   {31'd0, fpu_wbck_busy},  32'd0);
        chk("mrst_ready",  {31'd0, fpu_o_ready},    32'd1);
        chk("mrst_fflags", {27'd0, csr_fflags_r},   32'd0);
        chk("mrst_intv",   {31'd0, int_wbck_valid}, 32'd0);
        chk("mrst_frf",    {31'd0, frf_wen},        32'd0);
        rst_n = 1'b1;
        int_wbck_ready = 1'b1;
        step();
        chk("post_rst_intv", {31'd0, int_wbck_valid}, 32'd0);
        chk("post_rst_busy", {31'd0, fpu_wbck_busy},  32'd0);
        chk("post_rst_flg",  {27'd0, csr_fflags_r},   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
